// File: rtl/sim_end_ctrl_pkg.sv
// Shared encodings for the end-of-simulation controller:
// FSM states, end-cause codes and mode bit positions.
package sim_end_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_DONE = 2'd1,
    CAUSE_TIME = 2'd2,
    CAUSE_IDLE = 2'd3
  } cause_t;

  localparam int MODE_TIME = 0;
  localparam int MODE_DONE = 1;

endpackage

// File: rtl/sim_end_ctrl_if.sv
// Control/status bundle between the run host (master) and sim_end_ctrl (slave).
interface sim_end_ctrl_if #(
  parameter int NUM_SRCS = 5,
  parameter int CNT_W    = 32,
  parameter int IDLE_W   = 16
);
  logic                arm;
  logic [1:0]          mode;
  logic [CNT_W-1:0]    finish_cycles;
  logic [IDLE_W-1:0]   idle_limit;
  logic [NUM_SRCS-1:0] src_done;
  logic [NUM_SRCS-1:0] done_mask;
  logic                host_active;
  logic                activity;
  logic                sim_end;
  logic                finish;
  logic [1:0]          end_cause;
  logic [CNT_W-1:0]    cycle_count;
  logic                busy;
  logic                cfg_err;

  modport master (
    output arm, mode, finish_cycles, idle_limit, src_done, done_mask,
           host_active, activity,
    input  sim_end, finish, end_cause, cycle_count, busy, cfg_err
  );

  modport slave (
    input  arm, mode, finish_cycles, idle_limit, src_done, done_mask,
           host_active, activity,
    output sim_end, finish, end_cause, cycle_count, busy, cfg_err
  );
endinterface

// File: rtl/sim_end_ctrl_sat_counter.sv
// Up-counter with synchronous clear; optionally holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !(SATURATE && (&count))) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/sim_end_ctrl.sv
// End-of-run controller: decides run completion from done/time/idle causes,
// raises sim_end, waits a drain window, then raises finish until reset.
module sim_end_ctrl
  import sim_end_pkg::*;
#(
  parameter int          NUM_SRCS       = 5,
  parameter int          CNT_W          = 32,
  parameter int          IDLE_W         = 16,
  parameter int unsigned DEFAULT_FINISH = 1000000,
  parameter int          DRAIN_CYCLES   = 100
) (
  input logic           clk,
  input logic           reset,
  sim_end_ctrl_if.slave bus
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  state_t              state;
  logic [1:0]          mode_l;
  logic [CNT_W-1:0]    limit_l;
  logic [IDLE_W-1:0]   idle_limit_l;
  logic [NUM_SRCS-1:0] mask_l;

  logic [NUM_SRCS-1:0] src_done_q;
  logic [NUM_SRCS-1:0] done_sticky;
  logic                host_q;
  logic                act_q;
  logic                host_seen;

  logic                sim_end_r;
  logic                finish_r;
  logic                busy_r;
  logic                cfg_err_r;
  cause_t              cause_r;

  logic [CNT_W-1:0]    cycle_count;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [DRAIN_W-1:0]  drain_cnt;

  logic                done_hit;
  logic                time_hit;
  logic                idle_hit;
  logic                any_hit;
  logic                arm_ok;
  cause_t              end_sel;

  // Traffic inputs are sampled once before use, adding one cycle to done/idle decisions.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_done_q <= '0;
      host_q     <= 1'b0;
      act_q      <= 1'b0;
    end else begin
      src_done_q <= bus.src_done;
      host_q     <= bus.host_active;
      act_q      <= bus.activity;
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    end_sel  = CAUSE_NONE;
    done_hit = mode_l[MODE_DONE] & host_seen & (&(done_sticky | ~mask_l));
    time_hit = mode_l[MODE_TIME] & (cycle_count >= limit_l);
    idle_hit = (idle_limit_l != '0) & host_seen & (idle_cnt >= idle_limit_l);
    any_hit  = done_hit | time_hit | idle_hit;
    arm_ok   = (bus.mode != 2'b00) || (bus.idle_limit != '0);
    if (done_hit)      end_sel = CAUSE_DONE;
    else if (time_hit) end_sel = CAUSE_TIME;
    else if (idle_hit) end_sel = CAUSE_IDLE;
  end

  sat_counter #(.WIDTH(CNT_W), .SATURATE(1'b1)) u_cycle_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == ST_IDLE),
    .enable ((state == ST_RUN) && !any_hit),
    .count  (cycle_count)
  );

  sat_counter #(.WIDTH(IDLE_W), .SATURATE(1'b1)) u_idle_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  ((state != ST_RUN) || act_q),
    .enable (state == ST_RUN),
    .count  (idle_cnt)
  );

  sat_counter #(.WIDTH(DRAIN_W), .SATURATE(1'b1)) u_drain_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != ST_DRAIN),
    .enable (state == ST_DRAIN),
    .count  (drain_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      mode_l       <= '0;
      limit_l      <= '0;
      idle_limit_l <= '0;
      mask_l       <= '0;
      done_sticky  <= '0;
      host_seen    <= 1'b0;
      sim_end_r    <= 1'b0;
      finish_r     <= 1'b0;
      busy_r       <= 1'b0;
      cfg_err_r    <= 1'b0;
      cause_r      <= CAUSE_NONE;
    end else begin
      cfg_err_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.arm) begin
            if (arm_ok) begin
              mode_l       <= bus.mode;
              limit_l      <= (bus.finish_cycles == '0) ? CNT_W'(DEFAULT_FINISH)
                                                        : bus.finish_cycles;
              idle_limit_l <= bus.idle_limit;
              mask_l       <= bus.done_mask;
              done_sticky  <= '0;
              host_seen    <= 1'b0;
              busy_r       <= 1'b1;
              state        <= ST_RUN;
            end else begin
              cfg_err_r <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          done_sticky <= done_sticky | src_done_q;
          host_seen   <= host_seen | host_q;
          if (any_hit) begin
            sim_end_r <= 1'b1;
            cause_r   <= end_sel;
            state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
            finish_r <= 1'b1;
            busy_r   <= 1'b0;
            state    <= ST_DONE;
          end
        end
        ST_DONE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.sim_end     = sim_end_r;
  assign bus.finish      = finish_r;
  assign bus.end_cause   = cause_r;
  assign bus.cycle_count = cycle_count;
  assign bus.busy        = busy_r;
  assign bus.cfg_err     = cfg_err_r;

endmodule

// File: tb/tb_sim_end_ctrl.sv
// Directed bench for sim_end_ctrl: edge 0 is the arm edge; inputs change 1ns after
// a rising edge and are sampled on the next one, outputs are checked at the same point.
module tb_sim_end_ctrl;

  localparam int NUM_SRCS = 5;
  localparam int CNT_W    = 32;
  localparam int IDLE_W   = 16;
  localparam int DEF_FIN  = 300;
  localparam int DRAIN    = 100;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sim_end_ctrl_if #(.NUM_SRCS(NUM_SRCS), .CNT_W(CNT_W), .IDLE_W(IDLE_W)) bus ();

  sim_end_ctrl #(
    .NUM_SRCS       (NUM_SRCS),
    .CNT_W          (CNT_W),
    .IDLE_W         (IDLE_W),
    .DEFAULT_FINISH (DEF_FIN),
    .DRAIN_CYCLES   (DRAIN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic arm_run(input logic [1:0] m, input logic [31:0] fc,
                         input logic [15:0] il, input logic [4:0] mk);
    bus.mode          = m;
    bus.finish_cycles = fc;
    bus.idle_limit    = il;
    bus.done_mask     = mk;
    bus.arm           = 1'b1;
    step(1);
    bus.arm = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset             = 1'b1;
    bus.arm           = 1'b0;
    bus.mode          = 2'b00;
    bus.finish_cycles = '0;
    bus.idle_limit    = '0;
    bus.src_done      = '0;
    bus.done_mask     = '0;
    bus.host_active   = 1'b0;
    bus.activity      = 1'b0;
    step(2);
    check("rst_sim_end", bus.sim_end, 0);
    check("rst_finish", bus.finish, 0);
    check("rst_cause", bus.end_cause, 0);
    check("rst_count", bus.cycle_count, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    reset = 1'b0;
    step(1);

    // Time cause, limit 20
    arm_run(2'b01, 32'd20, 16'd0, 5'h1F);
    check("t_busy", bus.busy, 1);
    check("t_count0", bus.cycle_count, 0);
    step(10);
    bus.arm = 1'b1; bus.mode = 2'b00; bus.idle_limit = '0; bus.finish_cycles = 32'd5;
    step(1);
    bus.arm = 1'b0;
    check("t_arm_ignored_cfg_err", bus.cfg_err, 0);
    check("t_count11", bus.cycle_count, 11);
    step(9);
    check("t_sim_end_early", bus.sim_end, 0);
    check("t_count20", bus.cycle_count, 20);
    step(1);
    check("t_sim_end", bus.sim_end, 1);
    check("t_cause", bus.end_cause, 2);
    check("t_count_frozen", bus.cycle_count, 20);
    step(DRAIN - 1);
    check("t_finish_early", bus.finish, 0);
    check("t_busy_drain", bus.busy, 1);
    step(1);
    check("t_finish", bus.finish, 1);
    check("t_busy_done", bus.busy, 0);
    arm_run(2'b01, 32'd5, 16'd0, 5'h1F);
    step(3);
    check("t_done_hold_sim_end", bus.sim_end, 1);
    check("t_done_hold_cause", bus.end_cause, 2);
    check("t_done_hold_count", bus.cycle_count, 20);
    check("t_done_hold_finish", bus.finish, 1);
    reset_dut();
    check("t_reset_sim_end", bus.sim_end, 0);
    check("t_reset_finish", bus.finish, 0);

    // Done cause gated by host_active
    arm_run(2'b10, 32'd1000, 16'd0, 5'h1F);
    step(9);
    bus.src_done = 5'h1F;
    step(1);
    bus.src_done = '0;
    step(39);
    check("d_no_host", bus.sim_end, 0);
    bus.host_active = 1'b1;
    step(2);
    check("d_sim_end_51", bus.sim_end, 0);
    step(1);
    check("d_sim_end_52", bus.sim_end, 1);
    check("d_cause", bus.end_cause, 1);
    check("d_count", bus.cycle_count, 51);
    bus.host_active = 1'b0;
    reset_dut();

    // Masked source 4, done and time coincide
    arm_run(2'b11, 32'd30, 16'd0, 5'h0F);
    step(28);
    bus.src_done = 5'h0F;
    bus.host_active = 1'b1;
    step(1);
    bus.src_done = '0;
    step(1);
    check("p_sim_end_30", bus.sim_end, 0);
    step(1);
    check("p_sim_end_31", bus.sim_end, 1);
    check("p_cause", bus.end_cause, 1);
    check("p_count", bus.cycle_count, 30);
    bus.host_active = 1'b0;
    reset_dut();

    // Idle timeout 8, activity through edge 40
    bus.host_active = 1'b1;
    bus.activity = 1'b1;
    arm_run(2'b00, 32'd0, 16'd8, 5'h1F);
    check("i_cfg_ok", bus.cfg_err, 0);
    check("i_busy", bus.busy, 1);
    step(40);
    bus.activity = 1'b0;
    step(9);
    check("i_sim_end_49", bus.sim_end, 0);
    step(1);
    check("i_sim_end_50", bus.sim_end, 1);
    check("i_cause", bus.end_cause, 3);
    check("i_count", bus.cycle_count, 49);
    bus.host_active = 1'b0;

    // Reset in the middle of the drain window, then a clean re-run
    step(10);
    check("r_in_drain", bus.busy, 1);
    reset_dut();
    check("r_sim_end", bus.sim_end, 0);
    check("r_cause", bus.end_cause, 0);
    check("r_busy", bus.busy, 0);
    check("r_count", bus.cycle_count, 0);
    check("r_finish", bus.finish, 0);
    arm_run(2'b01, 32'd5, 16'd0, 5'h1F);
    step(5);
    check("r2_sim_end_5", bus.sim_end, 0);
    step(1);
    check("r2_sim_end_6", bus.sim_end, 1);
    check("r2_cause", bus.end_cause, 2);
    step(DRAIN - 1);
    check("r2_finish_early", bus.finish, 0);
    step(1);
    check("r2_finish", bus.finish, 1);
    reset_dut();

    // Zero budget uses the default limit
    arm_run(2'b01, 32'd0, 16'd0, 5'h1F);
    step(DEF_FIN);
    check("f_sim_end_early", bus.sim_end, 0);
    check("f_count", bus.cycle_count, DEF_FIN);
    step(1);
    check("f_sim_end", bus.sim_end, 1);
    check("f_cause", bus.end_cause, 2);
    reset_dut();

    // Arm with no enabled cause
    arm_run(2'b00, 32'd50, 16'd0, 5'h1F);
    check("c_cfg_err", bus.cfg_err, 1);
    check("c_busy", bus.busy, 0);
    step(1);
    check("c_cfg_err_pulse", bus.cfg_err, 0);
    check("c_busy_after", bus.busy, 0);
    check("c_sim_end", bus.sim_end, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
